// File: rtl/uart_rx.sv
// uart_rx -- UART receiver, 8 data bits LSB first, 1 stop bit, optional even
// parity. Bit timing matches UART_TX on the same clock for loopback.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined     -> PARITY state built, parity_err port present, 11-bit frame
//   not defined -> no parity handling, 10-bit frame
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx         in   serial input, idle high, asynchronous to clk
//   data_out   out  [7:0] last correctly received byte, held until next good frame
//   done       out  one-cycle pulse: good frame landed in data_out
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   parity_err out  one-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)
//   busy       out  high whenever the receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       done,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            done_q, done_d;
  logic            frame_err_q, frame_err_d;
  logic            armed_q, armed_d;
  logic            rx_s;
  logic            perr_w;

`ifdef UART_RX_PARITY_EN
  logic            perr_q, perr_d;
  logic            parity_err_q, parity_err_d;
  assign perr_w     = perr_q;
  assign parity_err = parity_err_q;
`else
  assign perr_w     = 1'b0;
`endif

  // Two-flop synchronizer; rx_s is the only view of the line the FSM uses.
  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];

  assign data_out  = data_out_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      sh_q         <= 8'h00;
      data_out_q   <= 8'h00;
      done_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      armed_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      data_out_q   <= data_out_d;
      done_q       <= done_d;
      frame_err_q  <= frame_err_d;
      armed_q      <= armed_d;
`ifdef UART_RX_PARITY_EN
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    sh_d         = sh_q;
    data_out_d   = data_out_q;
    done_d       = 1'b0;
    frame_err_d  = 1'b0;
    armed_d      = armed_q;
`ifdef UART_RX_PARITY_EN
    perr_d       = perr_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // After a framing error the line may sit low (break); wait for it to
        // return high before accepting another start edge.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = 3'd0;
          // Line back high at mid start bit: a glitch, drop it silently.
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // LSB arrives first; entering at the MSB aligns the byte after 8 shifts.
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = rx_s ^ (^sh_q);
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end else if (perr_w) begin
`ifdef UART_RX_PARITY_EN
            parity_err_d = 1'b1;
`endif
          end else begin
            data_out_d = sh_q;
            done_d     = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes the expected output pulse
// (kind, byte, cycle) into a queue; a negedge monitor pops and compares
// whenever done/frame_err/parity_err is seen.
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam longint DONE_LAT  = 171;
  localparam longint FRAME_LEN = 176;
`else
  localparam longint DONE_LAT  = 155;
  localparam longint FRAME_LEN = 160;
`endif

  localparam int K_NONE = -1;
  localparam int K_DONE = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    longint     cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       done;
  logic       frame_err;
  logic       perr_sig;
  logic       busy;

  int     checks = 0;
  int     errors = 0;
  longint edge_cnt = 0;
  exp_t   sb_q[$];
  logic [7:0] exp_data = 8'h00;
  longint done_cycles[$];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .done      (done),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(perr_sig),
`endif
    .busy      (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign perr_sig = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor / scoreboard consumer.
  logic [7:0] prev_data;
  logic       prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (done || frame_err || perr_sig) begin
        int kind;
        exp_t e;
        kind = done ? K_DONE : (frame_err ? K_FERR : K_PERR);
        check("pulse_exclusive", $countones({done, frame_err, perr_sig}), 1);
        check("busy_at_pulse", busy, 0);
        if (done) done_cycles.push_back(edge_cnt);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: kind %0d data %0h at edge %0d, none expected",
                   kind, data_out, edge_cnt);
        end else begin
          e = sb_q.pop_front();
          $display("frame: kind %0d data %0h edge %0d (expected kind %0d data %0h edge %0d)",
                   kind, data_out, edge_cnt, e.kind, e.data, e.cyc);
          check("pulse_kind", kind, e.kind);
          check("data_out", data_out, e.data);
          check("pulse_cycle", edge_cnt, e.cyc);
        end
      end
      if (prev_valid && !done) check("data_hold", data_out, prev_data);
      prev_data  = data_out;
      prev_valid = 1'b1;
    end
  end

  // Drives one frame starting at the current negedge; the expected pulse is
  // pushed before the line moves. Leaves rx at the stop-bit value.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int kind, input logic bad_par);
    exp_t e;
    e.kind = kind;
    e.cyc  = edge_cnt + DONE_LAT;
    if (kind == K_DONE) exp_data = d;
    e.data = exp_data;
    if (kind != K_NONE) sb_q.push_back(e);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    repeat (C) @(negedge clk);
`else
    if (bad_par) rx = 1'b1;
`endif
    rx = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t0;
    logic   seen;
    logic [7:0] pd;

    // Reset with idle line.
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data_out", data_out, 8'h00);
    check("rst_done", done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", perr_sig, 0);
    check("rst_busy", busy, 0);
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("idle_busy_200", seen, 0);

    // Frame 8'hAA, with busy rise timing.
    t0 = edge_cnt;
    fork
      send_frame(8'hAA, 1'b1, K_DONE, 1'b0);
      begin
        repeat (2) @(negedge clk);
        check("busy_before_rise", busy, 0);
        @(negedge clk);
        check("busy_rise", busy, 1);
      end
    join
    if (edge_cnt != t0 + FRAME_LEN) check("frame_len_sanity", edge_cnt, t0 + FRAME_LEN);
    repeat (20) @(negedge clk);

    // Back-to-back 8'h01, 8'hFF.
    done_cycles.delete();
    send_frame(8'h01, 1'b1, K_DONE, 1'b0);
    send_frame(8'hFF, 1'b1, K_DONE, 1'b0);
    repeat (20) @(negedge clk);
    check("b2b_done_count", done_cycles.size(), 2);
    if (done_cycles.size() == 2)
      check("b2b_spacing", done_cycles[1] - done_cycles[0], FRAME_LEN);

    // 4-cycle low glitch: no pulse, busy drops after edge 10.
    t0 = edge_cnt;
    rx = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 4) rx = 1'b1;
      if (k == 2)  check("glitch_busy_k2", busy, 0);
      if (k == 3)  check("glitch_busy_k3", busy, 1);
      if (k == 10) check("glitch_busy_k10", busy, 1);
      if (k == 11) check("glitch_busy_k11", busy, 0);
    end
    repeat (20) @(negedge clk);

    // 8'h55 with stop bit low: frame_err, data_out holds 8'hFF, line held
    // low afterwards must not start a new frame.
    send_frame(8'h55, 1'b0, K_FERR, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    check("break_no_restart", seen, 0);
    check("ferr_data_hold", data_out, 8'hFF);
    rx = 1'b1;
    repeat (20) @(negedge clk);

    // Reset during data bit 4 of 8'h3C.
    pd = 8'h3C;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx = pd[i];
      repeat ((i < 4) ? C : C / 2) @(negedge clk);
    end
    check("midframe_busy", busy, 1);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    rx = 1'b1;
    exp_data = 8'h00;
    @(negedge clk);
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (20) @(negedge clk);
    send_frame(8'hC3, 1'b1, K_DONE, 1'b0);
    repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 8'h07 with parity bit 0 (even parity needs 1).
    send_frame(8'h07, 1'b1, K_PERR, 1'b1);
    repeat (20) @(negedge clk);
    check("perr_data_hold", data_out, 8'hC3);
`endif

    // Drain the scoreboard.
    for (int w = 0; w < 400 && sb_q.size() != 0; w++) @(negedge clk);
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse: got none expected kind %0d data %0h edge %0d",
               e.kind, e.data, e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the counterpart to the existing `UART_TX`, on the same single clock. It recovers 8-bit frames from the serial `rx` line: 1 start bit, 8 data bits LSB first, optional even parity, 1 stop bit. Output is a byte plus a one-cycle `done` strobe. It sits at the host-link input of the neural-network datapath and is bit-timing compatible with `UART_TX` for loopback.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit. Even, ≥ 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `rx`  in  1  serial input; idle high; asynchronous to `clk`.
- `data_out`  out  8  last correctly received byte; held until the next good frame.
- `done`  out  1  one-cycle pulse: a good frame has landed in `data_out`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch. Present only with `UART_RX_PARITY_EN`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Synchronizer: `rx` passes through 2 flops, giving `rx_s`. All decisions use `rx_s`. Flop reset value is 1.
- Bit counter `cnt`: width $clog2(CLKS_PER_BIT). Bit index `idx`: 3 bits.
- Shift register `sh`: 8 bits. Sampled bit enters at the MSB and shifts right, so LSB-first data is byte-aligned after 8 shifts.
- FSM states:
  - IDLE: when `armed` && `rx_s`==0, go to START with `cnt`=0. `armed` clears on a framing error and sets again when `rx_s`==1.
  - START: at `cnt`==CLKS_PER_BIT/2−1 (mid start bit), re-sample. If `rx_s`==1, treat as a glitch and return to IDLE with no output pulse. Otherwise go to DATA with `cnt`=0 and `idx`=0.
  - DATA: at `cnt`==CLKS_PER_BIT−1, shift `rx_s` into `sh` and reset `cnt`. Stay while `idx`<7. After the `idx`==7 sample, go to PARITY if the macro is defined, else STOP.
  - PARITY: at `cnt`==CLKS_PER_BIT−1, latch `perr` = `rx_s` ^ (^`sh`), then go to STOP.
  - STOP: at `cnt`==CLKS_PER_BIT−1, sample `rx_s`:
    - 1 and no `perr`: `data_out`<=`sh`, `done`<=1.
    - 1 with `perr`: `parity_err`<=1; `data_out` unchanged.
    - 0: `frame_err`<=1; `data_out` unchanged; `armed`<=0.
    - In every case, go to IDLE.
- Back-to-back frames: IDLE can accept a new start edge on the cycle after leaving STOP. This covers the remaining half stop bit.
- Reset, including mid-frame: state=IDLE, `cnt`=0, `idx`=0, `sh`=0, `data_out`=8'h00, `done`=`frame_err`=`parity_err`=0, `busy`=0, `armed`=1, sync flops=1. The partial frame is discarded.

## Timing
- Cycle 0 is the first rising edge at which `rx`=0 is captured. `rx_s` goes low after edge 1; IDLE moves to START at edge 2.
- Mid-start sample at edge 2+CLKS_PER_BIT/2.
- Data bit i sampled at edge 2+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
- Stop bit sampled at edge 2+CLKS_PER_BIT/2+9·CLKS_PER_BIT. `done` is high in the following cycle.
  - Default (CLKS_PER_BIT=16): `done` high in cycle 155.
  - With parity: add CLKS_PER_BIT (171).
- `done`, `frame_err` and `parity_err` are mutually exclusive; each is high for exactly 1 cycle per frame.
- `data_out` changes only on the same edge that raises `done`.
- `busy` rises 2 cycles after cycle 0 and falls with the output pulse.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is built, using even parity over the 8 data bits.
  - `parity_err` port exists.
  - Frame is 11 bits.
- Not defined:
  - No PARITY state, no `parity_err` port.
  - Frame is 10 bits.
  - `UART_TX` frames are accepted unchanged.

## Test plan
- Idle line, then `rst` pulse: all outputs at their reset values; `busy`=0 for 200 cycles with `rx`=1.
- Drive frame 8'hAA at CLKS_PER_BIT=16 (loopback from `UART_TX`, `data_in`=8'b10101010) → `done`=1 in cycle 155, `data_out`=8'hAA, `frame_err`=0.
- Two back-to-back frames, 8'h01 then 8'hFF, with 1-bit stop → two `done` pulses 160 cycles apart; `data_out` is 8'h01, then 8'hFF.
- `rx` low pulse of 4 cycles → no pulse; `busy` returns to 0 at edge 10.
- Frame 8'h55 with stop bit forced 0 → `frame_err` pulse; `data_out` keeps its previous value; no new frame is accepted until `rx` returns high.
- Assert `rst` during data bit 4 of frame 8'h3C → outputs reset; a following clean 8'hC3 frame gives `done` with `data_out`=8'hC3. With `UART_RX_PARITY_EN` defined, send 8'h07 with parity bit 0 → `parity_err` pulse and no `done`.
